// File: rtl/ssd_scan_ctrl.sv
// Four-digit seven-segment scan controller: per-digit refresh, 1 Hz blink and a
// one-shot timed overlay that temporarily replaces the base frame.
module ssd_scan_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 50000000,
    parameter int OVL_HOLD    = 200000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] frame,
    input  logic [3:0]  blink_mask,
    input  logic        ovl_req,
    input  logic [19:0] ovl_frame,
    output logic        ovl_ack,
    output logic        ovl_busy,
    output logic [4:0]  digit_code,
    output logic [3:0]  active_digit,
    output logic        blink_phase
);
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int HW = (OVL_HOLD > 1) ? $clog2(OVL_HOLD) : 1;
    localparam logic [4:0] BLANK = 5'b10101;

    typedef enum logic {IDLE, SHOW} state_t;

    state_t          state, state_nxt;
    logic [RW-1:0]   ref_cnt;
    logic [BW-1:0]   blink_cnt;
    logic [HW-1:0]   hold_cnt, hold_nxt;
    logic [1:0]      idx, idx_nxt;
    logic            phase_nxt;
    logic [19:0]     ovl_lat, ovl_lat_nxt;
    logic            ack_nxt;
    logic            ref_tc, blink_tc, hold_tc;
    logic [19:0]     src;
    logic [4:0]      code_nxt;
    logic [3:0]      digit_nxt;

    assign ref_tc    = (ref_cnt == RW'(REFRESH_DIV - 1));
    assign blink_tc  = (blink_cnt == BW'(BLINK_DIV - 1));
    assign hold_tc   = (hold_cnt == HW'(OVL_HOLD - 1));
    assign idx_nxt   = ref_tc ? idx + 2'd1 : idx;
    assign phase_nxt = blink_tc ? ~blink_phase : blink_phase;
    assign ovl_busy  = (state == SHOW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt   <= '0;
            blink_cnt <= '0;
            idx       <= 2'd0;
        end else begin
            ref_cnt   <= ref_tc ? '0 : ref_cnt + 1'b1;
            blink_cnt <= blink_tc ? '0 : blink_cnt + 1'b1;
            idx       <= idx_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            ovl_lat  <= '0;
            ovl_ack  <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            ovl_lat  <= ovl_lat_nxt;
            ovl_ack  <= ack_nxt;
        end
    end

    // Requests are only honoured in IDLE, so a held request re-arms on the first IDLE cycle.
    always_comb begin
        state_nxt   = state;
        hold_nxt    = hold_cnt;
        ovl_lat_nxt = ovl_lat;
        ack_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (ovl_req) begin
                    state_nxt   = SHOW;
                    hold_nxt    = '0;
                    ovl_lat_nxt = ovl_frame;
                    ack_nxt     = 1'b1;
                end
            end
            SHOW: begin
                if (hold_tc) begin
                    state_nxt = IDLE;
                    hold_nxt  = '0;
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Display outputs are built from the post-edge source, index and phase.
    always_comb begin
        src       = (state_nxt == SHOW) ? ovl_lat_nxt : frame;
        code_nxt  = BLANK;
        digit_nxt = 4'b0111;
        case (idx_nxt)
            2'd0: begin code_nxt = src[19:15]; digit_nxt = 4'b0111; end
            2'd1: begin code_nxt = src[14:10]; digit_nxt = 4'b1011; end
            2'd2: begin code_nxt = src[9:5];   digit_nxt = 4'b1101; end
            default: begin code_nxt = src[4:0]; digit_nxt = 4'b1110; end
        endcase
        if (state_nxt == IDLE && !phase_nxt && blink_mask[2'd3 - idx_nxt])
            code_nxt = BLANK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_code   <= BLANK;
            active_digit <= 4'b0111;
            blink_phase  <= 1'b1;
        end else begin
            digit_code   <= code_nxt;
            active_digit <= digit_nxt;
            blink_phase  <= phase_nxt;
        end
    end
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Randomized bench for ssd_scan_ctrl with an edge-counting reference model.
module tb_ssd_scan_ctrl;
    localparam int R = 4, B = 16, H = 10;
    localparam logic [19:0] CLSD = 20'b01100_10000_00101_10001;
    localparam logic [19:0] OPEN = 20'b00000_10010_01110_10011;
    localparam logic [4:0]  BLANK = 5'b10101;

    logic        clk = 0, rst = 1;
    logic [19:0] frame = CLSD, ovl_frame = '0;
    logic [3:0]  blink_mask = '0;
    logic        ovl_req = 0;
    logic        ovl_ack, ovl_busy, blink_phase;
    logic [4:0]  digit_code;
    logic [3:0]  active_digit;

    int total = 0, bad = 0;

    ssd_scan_ctrl #(.REFRESH_DIV(R), .BLINK_DIV(B), .OVL_HOLD(H)) dut (
        .clk(clk), .rst(rst), .frame(frame), .blink_mask(blink_mask),
        .ovl_req(ovl_req), .ovl_frame(ovl_frame), .ovl_ack(ovl_ack),
        .ovl_busy(ovl_busy), .digit_code(digit_code),
        .active_digit(active_digit), .blink_phase(blink_phase));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: edges since reset determine slot and blink phase directly.
    int          k, rem;
    bit          show;
    logic [19:0] lat;
    logic [4:0]  e_code;
    logic [3:0]  e_dig;
    logic        e_phase, e_ack, e_busy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            k = 0; show = 0; rem = 0; lat = '0;
            e_code = BLANK; e_dig = 4'b0111; e_phase = 1; e_ack = 0; e_busy = 0;
        end else begin
            int slot;
            logic [19:0] s;
            k++;
            e_ack = 0;
            if (!show) begin
                if (ovl_req) begin show = 1; rem = H; lat = ovl_frame; e_ack = 1; end
            end else begin
                rem--;
                if (rem == 0) show = 0;
            end
            slot = (k / R) % 4;
            e_phase = ((k / B) % 2) == 0;
            s = show ? lat : frame;
            e_code = s[19 - 5*slot -: 5];
            e_dig = 4'b1111 & ~(4'b1000 >> slot);
            if (!show && !e_phase && blink_mask[3 - slot]) e_code = BLANK;
            e_busy = show;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("digit_code", 32'(digit_code), 32'(e_code));
        chk("active_digit", 32'(active_digit), 32'(e_dig));
        chk("blink_phase", 32'(blink_phase), 32'(e_phase));
        chk("ovl_ack", 32'(ovl_ack), 32'(e_ack));
        chk("ovl_busy", 32'(ovl_busy), 32'(e_busy));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic busy_len(input string nm, input int exp);
        int n = 1;
        int guard = 0;
        tick(1);
        while (ovl_busy && guard < 50) begin n++; guard++; tick(1); end
        chk(nm, 32'(n), 32'(exp));
    endtask

    initial begin
        tick(3);
        chk("rst_digit", 32'(active_digit), 32'h7);
        chk("rst_code", 32'(digit_code), 32'(BLANK));
        chk("rst_phase", 32'(blink_phase), 32'h1);
        chk("rst_busy", 32'(ovl_busy), 32'h0);
        rst = 0;
        // Scan order
        tick(1);
        chk("scan0_dig", 32'(active_digit), 32'h7);
        chk("scan0_code", 32'(digit_code), 32'b01100);
        tick(3);
        chk("scan1_dig", 32'(active_digit), 32'hb);
        chk("scan1_code", 32'(digit_code), 32'b10000);
        tick(4);
        chk("scan2_dig", 32'(active_digit), 32'hd);
        chk("scan2_code", 32'(digit_code), 32'b00101);
        tick(4);
        chk("scan3_dig", 32'(active_digit), 32'he);
        chk("scan3_code", 32'(digit_code), 32'b10001);
        tick(4);
        chk("wrap_code", 32'(digit_code), 32'b01100);
        chk("phase_tog", 32'(blink_phase), 32'h0);
        // Blinking leftmost digit
        blink_mask = 4'b1000;
        tick(1);
        chk("blink_blank", 32'(digit_code), 32'(BLANK));
        tick(64);
        // Overlay display with everything masked
        blink_mask = 4'b1111; ovl_frame = OPEN; ovl_req = 1;
        tick(1);
        ovl_req = 0;
        chk("ovl_ack", 32'(ovl_ack), 32'h1);
        busy_len("ovl_busy_len", H);
        tick(40);
        // Request pulse during SHOW is ignored
        ovl_req = 1; tick(1); ovl_req = 0;
        tick(3); ovl_req = 1; tick(1); ovl_req = 0;
        busy_len("show_req_len", H - 4);
        tick(5);
        // Request held through the end of SHOW
        ovl_req = 1; tick(1);
        while (ovl_busy && total < 100000) tick(1);
        chk("gap_busy", 32'(ovl_busy), 32'h0);
        chk("gap_ack", 32'(ovl_ack), 32'h0);
        tick(1);
        chk("rearm_ack", 32'(ovl_ack), 32'h1);
        chk("rearm_busy", 32'(ovl_busy), 32'h1);
        ovl_req = 0;
        tick(4);
        // Reset mid-SHOW
        @(posedge clk); #2 rst = 1; #1;
        chk("arst_dig", 32'(active_digit), 32'h7);
        chk("arst_code", 32'(digit_code), 32'(BLANK));
        chk("arst_busy", 32'(ovl_busy), 32'h0);
        chk("arst_ack", 32'(ovl_ack), 32'h0);
        @(negedge clk); rst = 0;
        blink_mask = 4'b0000;
        tick(1);
        // Frame change mid-slot
        frame = 20'b10100_00011_00111_01001;
        tick(1);
        chk("frame_chg", 32'(digit_code), 32'b10100);
        tick(8);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) frame = 20'($urandom);
            if ($urandom_range(0, 15) == 0) blink_mask = 4'($urandom);
            ovl_frame = 20'($urandom);
            ovl_req = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 499) == 0);
            tick(1);
        end
        rst = 0; ovl_req = 0;
        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ssd_scan_ctrl.md
Name: ssd_scan_ctrl

Overview:
Time-multiplexed scan controller for the 4-digit seven-segment display. It takes the lock FSM's packed 20-bit display frame (four 5-bit symbol codes), scans one digit at a time and applies 1 Hz per-digit blinking. It also arbitrates between that persistent frame and a one-shot timed overlay message (e.g. "OPEn"). It drives the 5-bit code into binary_to_segment and the active-low digit enables.

Parameters:
REFRESH_DIV, 100000, clock cycles each digit stays active (1 kHz per digit at 100 MHz); must be ≥1
BLINK_DIV, 50000000, clock cycles per blink half-period (1 Hz blink at 100 MHz); must be ≥1
OVL_HOLD, 200000000, clock cycles an accepted overlay is displayed; must be ≥1

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
frame  input  20  base frame; [19:15] leftmost digit … [4:0] rightmost digit
blink_mask  input  4  per-digit blink enable; bit 3 = leftmost digit
ovl_req  input  1  overlay request, level-sampled
ovl_frame  input  20  overlay frame, same packing as frame
ovl_ack  output  1  one-cycle pulse when the overlay is accepted
ovl_busy  output  1  high while the overlay is displayed
digit_code  output  5  symbol code to binary_to_segment
active_digit  output  4  active-low digit enable
blink_phase  output  1  1 = visible half, 0 = blanked half

Behaviour:
- Reset is asynchronous, active-high, on clock clk. On reset:
  - active_digit=4'b0111, digit_code=5'b10101 (BLANK), blink_phase=1, ovl_ack=0, ovl_busy=0.
  - All counters are 0, the scan index is 0, and the overlay FSM is in IDLE.
- Scan:
  - The refresh counter runs 0..REFRESH_DIV-1. At terminal count the index advances 0→1→2→3→0.
  - Index 0/1/2/3 selects active_digit 0111/1011/1101/1110 and frame slice [19:15]/[14:10]/[9:5]/[4:0].
  - Outputs are registered every cycle from the current index and source. A frame or mask change is therefore visible on the next clock edge.
- Blink:
  - The free-running blink counter runs 0..BLINK_DIV-1 and toggles blink_phase at terminal count.
  - If blink_phase=0 and the mask bit of the displayed digit is 1, digit_code=BLANK and active_digit is still driven.
  - The blink counter is never cleared by overlay activity; only rst clears it.
- Overlay FSM, states IDLE and SHOW:
  - IDLE: ovl_req=1 → latch ovl_frame, pulse ovl_ack for exactly 1 cycle (the next edge), go to SHOW, clear the hold counter, set ovl_busy=1.
  - SHOW: display the latched overlay frame. blink_mask is ignored (no blanking). The hold counter counts 0..OVL_HOLD-1; at terminal count go to IDLE with ovl_busy=0.
  - ovl_req in SHOW is ignored: no ack, no restart, latched frame unchanged.
  - A req still high when SHOW ends is accepted on the first IDLE cycle. IDLE therefore lasts ≥1 cycle, and that cycle displays the base frame.
  - The scan index continues across IDLE↔SHOW transitions without resetting.
- Simultaneous events: scan advance, blink toggle and overlay entry/exit in the same cycle all take effect together. The output register uses the post-edge source, index and phase.
- Reset mid-operation: outputs go to reset values immediately and asynchronously. A pending or displayed overlay is dropped and no ack is issued.

Test Plan:
Use REFRESH_DIV=4, BLINK_DIV=16, OVL_HOLD=10 for all scenarios.
1. Scan order: release rst with frame=01100_10000_00101_10001 (CLSd), mask=0 → active_digit 0111,1011,1101,1110 for 4 cycles each, codes 01100,10000,00101,10001, then wrap to 0111/01100.
2. Blinking: mask=4'b1000 → leftmost slot code alternates 01100 (16 cycles) and 10101 (16 cycles) in step with blink_phase; the other three digits never blank.
3. Overlay display: 1-cycle ovl_req with ovl_frame=00000_10010_01110_10011 (OPEn) and mask=4'b1111 → ovl_ack high 1 cycle, ovl_busy high exactly 10 cycles, codes 00000/10010/01110/10011 unblanked, then CLSd with blinking resumes.
4. Request during SHOW: pulse ovl_req mid-SHOW → no ack and busy length unchanged; hold ovl_req high through the end → busy low 1 cycle, then a new ack and busy.
5. Reset mid-SHOW: assert rst between edges → active_digit=0111, digit_code=10101, ovl_busy=0 and ovl_ack=0 immediately; after release the base frame shows and no ack is issued.
6. Frame change: change frame mid-slot → digit_code reflects the new slice on the next edge.
